// File: rtl/max7219_cmd_scheduler.sv
// Arbitrates init, refresh-frame and intensity command words for the MAX7219
// onto a single valid/ready link towards the serial shifter.
module max7219_cmd_scheduler #(
  parameter int          NUM_DIGITS  = 8,
  parameter logic [7:0]  DECODE_MODE = 8'h00
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_en,
  input  logic        i_refresh_stb,
  input  logic [63:0] i_digits,
  input  logic [3:0]  i_intensity,
  output logic [15:0] o_word,
  output logic        o_word_valid,
  input  logic        i_word_ready,
  output logic        o_busy,
  output logic        o_init_done,
  output logic        o_frame_done
);

  typedef enum logic [1:0] {INIT, IDLE, FRAME, CFG} state_t;

  localparam logic [2:0] LAST_DIGIT = 3'(NUM_DIGITS - 1);
  localparam logic [2:0] LAST_INIT  = 3'd4;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        valid_q, valid_d;
  logic [15:0] word_q, word_d;
  logic [63:0] snap_q, snap_d;
  logic        pend_q, pend_d;
  logic [3:0]  last_int_q, last_int_d;
  logic        init_done_q, init_done_d;
  logic        frame_done_q, frame_done_d;
  logic        busy_q, busy_d;
  logic        xfer;
  logic        clr_pend;

  function automatic logic [15:0] init_word(input logic [2:0] idx, input logic [3:0] inten);
    case (idx)
      3'd0:    init_word = 16'h0C01;
      3'd1:    init_word = {8'h0B, 8'(NUM_DIGITS - 1)};
      3'd2:    init_word = {8'h09, DECODE_MODE};
      3'd3:    init_word = {8'h0A, 4'h0, inten};
      default: init_word = 16'h0F00;
    endcase
  endfunction

  assign xfer = valid_q & i_word_ready;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    valid_d      = valid_q;
    word_d       = word_q;
    snap_d       = snap_q;
    last_int_d   = last_int_q;
    init_done_d  = init_done_q;
    frame_done_d = 1'b0;
    clr_pend     = 1'b0;
    case (state_q)
      INIT: begin
        if (!valid_q) begin
          valid_d = 1'b1;
          word_d  = init_word(idx_q, i_intensity);
        end else if (xfer) begin
          valid_d = 1'b0;
          if (idx_q == 3'd3) last_int_d = word_q[3:0];
          if (idx_q == LAST_INIT) begin
            init_done_d = 1'b1;
            state_d     = FRAME;
            idx_d       = 3'd0;
            snap_d      = i_digits;
            clr_pend    = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      IDLE: begin
        // Intensity outranks refresh so a brightness change is never starved.
        if (i_en && (i_intensity != last_int_q)) begin
          state_d = CFG;
        end else if (i_en && pend_q) begin
          state_d  = FRAME;
          idx_d    = 3'd0;
          snap_d   = i_digits;
          clr_pend = 1'b1;
        end
      end
      FRAME: begin
        if (!valid_q) begin
          valid_d = 1'b1;
          word_d  = {{5'b0, idx_q} + 8'd1, snap_q[{idx_q, 3'b000} +: 8]};
        end else if (xfer) begin
          valid_d = 1'b0;
          if (idx_q == LAST_DIGIT) begin
            frame_done_d = 1'b1;
            state_d      = IDLE;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: begin
        if (!valid_q) begin
          valid_d = 1'b1;
          word_d  = {8'h0A, 4'h0, i_intensity};
        end else if (xfer) begin
          valid_d    = 1'b0;
          last_int_d = word_q[3:0];
          state_d    = IDLE;
        end
      end
    endcase
    // Pending is dropped when a frame starts; strobes during the frame re-arm it.
    pend_d = i_refresh_stb | (pend_q & ~clr_pend);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= INIT;
      idx_q        <= 3'd0;
      valid_q      <= 1'b0;
      word_q       <= 16'h0000;
      pend_q       <= 1'b0;
      last_int_q   <= 4'h0;
      init_done_q  <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      valid_q      <= valid_d;
      word_q       <= word_d;
      pend_q       <= pend_d;
      last_int_q   <= last_int_d;
      init_done_q  <= init_done_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  always_ff @(posedge i_clk) begin
    snap_q <= snap_d;
  end

  assign o_word       = word_q;
  assign o_word_valid = valid_q;
  assign o_busy       = busy_q;
  assign o_init_done  = init_done_q;
  assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_max7219_cmd_scheduler.sv
// Directed bench for max7219_cmd_scheduler: table of refresh frames plus
// hand-written init, backpressure, coalescing, enable and reset sequences.
module tb_max7219_cmd_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        stb;
  logic [63:0] digits;
  logic [3:0]  inten;
  logic [15:0] word;
  logic        valid;
  logic        ready;
  logic        busy;
  logic        init_done;
  logic        frame_done;

  int errors = 0;
  int checks = 0;
  int fd_cnt = 0;
  logic [15:0] q[$];

  typedef struct {
    logic [63:0]  digits;
    logic [127:0] exp;
  } frame_vec_t;

  frame_vec_t tbl[3];

  max7219_cmd_scheduler #(.NUM_DIGITS(8), .DECODE_MODE(8'h00)) dut (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_refresh_stb(stb),
    .i_digits(digits), .i_intensity(inten), .o_word(word),
    .o_word_valid(valid), .i_word_ready(ready), .o_busy(busy),
    .o_init_done(init_done), .o_frame_done(frame_done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (valid && ready) q.push_back(word);
      if (frame_done) fd_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wait_words(input int n, input int budget, input string name);
    int c = 0;
    while (q.size() < n && c < budget) begin
      @(negedge clk); #1;
      c++;
    end
    if (q.size() < n) begin
      checks++;
      errors++;
      $display("FAIL %s: timeout with %0d words, expected %0d", name, q.size(), n);
    end
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    while (busy && c < budget) begin
      @(negedge clk); #1;
      c++;
    end
  endtask

  task automatic pulse_stb();
    @(posedge clk); #1 stb = 1'b1;
    @(posedge clk); #1 stb = 1'b0;
  endtask

  task automatic check_frame(input string name, input logic [127:0] exp, input int base);
    for (int k = 0; k < 8; k++) begin
      logic [15:0] e;
      e = exp[127 - 16*k -: 16];
      if (q.size() > base + k) check(name, {16'h0, q[base + k]}, {16'h0, e});
      else check(name, 32'hFFFF_FFFF, {16'h0, e});
    end
  endtask

  initial begin
    logic [15:0] init_exp[5];
    int c;
    tbl[0] = '{64'h7E30_6D79_337B_5F70, 128'h0170_025F_037B_0433_0579_066D_0730_087E};
    tbl[1] = '{64'h0000_0000_0000_00FF, 128'h01FF_0200_0300_0400_0500_0600_0700_0800};
    tbl[2] = '{64'h8040_2010_0804_0201, 128'h0101_0202_0304_0408_0510_0620_0740_0880};
    init_exp = '{16'h0C01, 16'h0B07, 16'h0900, 16'h0A07, 16'h0F00};

    rst = 1'b1; en = 1'b1; stb = 1'b0; ready = 1'b1; inten = 4'h7;
    digits = 64'h0807_0605_0403_0201;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_valid", {31'h0, valid}, 32'h0);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_init_done", {31'h0, init_done}, 32'h0);
    check("reset_frame_done", {31'h0, frame_done}, 32'h0);
    check("reset_word", {16'h0, word}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;

    // Init sequence followed immediately by the forced first frame.
    wait_words(13, 200, "init_timeout");
    for (int i = 0; i < 5; i++)
      if (q.size() > i) check("init_word", {16'h0, q[i]}, {16'h0, init_exp[i]});
    check("init_done", {31'h0, init_done}, 32'h1);
    check_frame("first_frame", 128'h0101_0202_0303_0404_0505_0606_0707_0808, 5);
    wait_idle(50);
    check("idle_busy", {31'h0, busy}, 32'h0);
    check("first_frame_done", fd_cnt, 1);

    for (int t = 0; t < 3; t++) begin
      q.delete(); fd_cnt = 0;
      digits = tbl[t].digits;
      pulse_stb();
      wait_words(8, 100, "table_timeout");
      repeat (4) @(negedge clk);
      check_frame("table_frame", tbl[t].exp, 0);
      check("table_frame_done", fd_cnt, 1);
      check("table_busy", {31'h0, busy}, 32'h0);
    end

    // Backpressure on the 3rd frame word, digits disturbed mid-frame.
    q.delete(); fd_cnt = 0;
    digits = tbl[0].digits;
    pulse_stb();
    wait_words(2, 100, "bp_timeout");
    @(posedge clk); #1 ready = 1'b0; digits = 64'h0;
    @(posedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold", {15'h0, valid, word}, {15'h0, 1'b1, 16'h037B});
    end
    @(posedge clk); #1 ready = 1'b1;
    wait_words(8, 100, "bp_timeout2");
    repeat (4) @(negedge clk);
    check_frame("bp_frame", tbl[0].exp, 0);
    check("bp_frame_done", fd_cnt, 1);

    // Coalesced strobes plus an intensity change during a frame.
    q.delete(); fd_cnt = 0;
    digits = tbl[0].digits;
    pulse_stb();
    wait_words(2, 100, "coal_timeout");
    inten = 4'hF;
    repeat (3) pulse_stb();
    wait_words(17, 200, "coal_timeout2");
    repeat (40) @(negedge clk);
    check("coal_count", q.size(), 17);
    if (q.size() > 8) check("coal_cfg", {16'h0, q[8]}, 32'h0A0F);
    check_frame("coal_frame2", tbl[0].exp, 9);
    check("coal_frame_done", fd_cnt, 2);

    // Enable low: current frame completes, pending strobe waits for enable.
    q.delete(); fd_cnt = 0;
    pulse_stb();
    wait_words(2, 100, "en_timeout");
    en = 1'b0;
    pulse_stb();
    wait_words(8, 100, "en_timeout2");
    repeat (30) @(negedge clk);
    check("en_hold_count", q.size(), 8);
    check("en_hold_done", fd_cnt, 1);
    check("en_hold_busy", {31'h0, busy}, 32'h0);
    @(posedge clk); #1 en = 1'b1;
    wait_words(16, 100, "en_resume_timeout");
    repeat (10) @(negedge clk);
    check("en_resume_count", q.size(), 16);
    check("en_resume_done", fd_cnt, 2);

    // Reset while the second init word is on the link.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    c = 0;
    @(negedge clk);
    while (!(valid && word == 16'h0B07) && c < 50) begin
      @(negedge clk);
      c++;
    end
    check("rst_mid_seen", {15'h0, valid, word}, {15'h0, 1'b1, 16'h0B07});
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_valid", {31'h0, valid}, 32'h0);
    check("rst_mid_init_done", {31'h0, init_done}, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    q.delete();
    wait_words(2, 50, "rst_restart_timeout");
    if (q.size() > 1) begin
      check("rst_restart_w0", {16'h0, q[0]}, 32'h0C01);
      check("rst_restart_w1", {16'h0, q[1]}, 32'h0B07);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
